cache_mem_responder: RTL and testbench

- Memory-side responder for the single-core cache protocol; the other end of the icache/dcache request interface.
- Serves icache fetches (iREN/iaddr) and dcache block transfers (dREN/dWEN/daddr/dstore), answering each with iwait/dwait and iload/dload.
- Arbitrates the two caches onto one RAM port that reports its status via ramstate (FREE/BUSY/ACCESS/ERROR).
- Keeps a dcache two-word block transfer atomic and prevents icache starvation.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/resp_arbiter_fsm.sv | 87 ++++++++
 rtl/cache_mem_responder.sv | 77 +++++++
 tb/tb_cache_mem_responder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types and responder defaults
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        DLOCK  = 2'd3
    } resp_state_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int LOCK_HOLD_DEF  = 2;

endpackage

// File: rtl/resp_arbiter_fsm.sv
// rtl/resp_arbiter_fsm.sv - icache/dcache grant FSM with starvation and block-lock counters
module resp_arbiter_fsm
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int LOCK_HOLD  = LOCK_HOLD_DEF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic        blk_word,
    input  ramstate_t   ramstate,
    output resp_state_t state
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int HW = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;

    resp_state_t   next_state;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          dreq;
    logic          access;

    assign dreq   = dREN | dWEN;
    assign access = (ramstate == ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            hold_cnt   <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= starve_nxt;
            hold_cnt   <= hold_nxt;
        end
    end

    always_comb begin
        next_state = state;
        starve_nxt = starve_cnt;
        hold_nxt   = hold_cnt;
        case (state)
            IDLE: begin
                hold_nxt = '0;
                if (iREN && starve_cnt == SW'(STARVE_MAX)) next_state = IGRANT;
                else if (dreq)                             next_state = DGRANT;
                else if (iREN)                             next_state = IGRANT;
            end
            IGRANT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else if (access) begin
                    next_state = IDLE;
                    starve_nxt = '0;
                end
            end
            DGRANT: begin
                hold_nxt = '0;
                if (!dreq) begin
                    next_state = IDLE;
                end else if (access) begin
                    // first word of a block keeps the port for the second word
                    next_state = blk_word ? IDLE : DLOCK;
                    if (!iREN)                              starve_nxt = '0;
                    else if (starve_cnt != SW'(STARVE_MAX)) starve_nxt = starve_cnt + 1'b1;
                end
            end
            DLOCK: begin
                if (dreq) begin
                    next_state = DGRANT;
                    hold_nxt   = '0;
                end else if (hold_cnt == HW'(LOCK_HOLD - 1)) begin
                    next_state = IDLE;
                    hold_nxt   = '0;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - arbitrates icache/dcache requests onto a single RAM port
module cache_mem_responder
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int LOCK_HOLD  = LOCK_HOLD_DEF
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    resp_state_t grant;

    resp_arbiter_fsm #(
        .STARVE_MAX (STARVE_MAX),
        .LOCK_HOLD  (LOCK_HOLD)
    ) u_fsm (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .blk_word (daddr[2]),
        .ramstate (ramstate),
        .state    (grant)
    );

    // Strobes follow the live request so a dropped request releases the port at once.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (grant)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (iREN && ramstate == ACCESS) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if ((dREN | dWEN) && ramstate == ACCESS) begin
                    dwait = 1'b0;
                    dload = dWEN ? '0 : ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - scoreboard bench for cache_mem_responder
module tb_cache_mem_responder;
    import cpu_types_pkg::*;

    logic      CLK, nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, iload, dload;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    cache_mem_responder dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        who;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] load;
        logic [31:0] store;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   nd;

    logic [3:0] lat, cnt;
    int         err_cfg, err_used;

    function automatic word_t ram_data(input word_t a);
        case (a)
            32'h0000_0040: return 32'hDEAD_BEEF;
            32'h0000_0000: return 32'h0000_1111;
            32'h0000_0080: return 32'hCAFE_0080;
            default:       return {16'hA5A5, a[15:0]};
        endcase
    endfunction

    always_comb begin
        ramstate = FREE;
        if (ramREN || ramWEN) begin
            if (err_used < err_cfg) ramstate = ERROR;
            else if (cnt >= lat)    ramstate = ACCESS;
            else                    ramstate = BUSY;
        end
        ramload = ram_data(ramaddr);
    end

    always @(posedge CLK) begin
        if (!(ramREN || ramWEN) || ramstate == ACCESS) begin
            cnt      <= 4'd0;
            err_used <= 0;
        end else if (ramstate == ERROR) begin
            err_used <= err_used + 1;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void expect_i(input word_t a, input word_t ld);
        sbq.push_back('{who: 1'b0, wr: 1'b0, addr: a, load: ld, store: 32'h0});
    endfunction

    function automatic void expect_d(input logic wr, input word_t a, input word_t ld, input word_t st);
        sbq.push_back('{who: 1'b1, wr: wr, addr: a, load: ld, store: st});
    endfunction

    always @(negedge CLK) begin
        if (!iwait || !dwait) begin
            chk("single_done", 32'(iwait ^ dwait), 32'd1);
            if (sbq.size() == 0) begin
                chk("pending_expect", 32'(sbq.size()), 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("who", 32'(iwait), 32'(e.who));
                chk("ramaddr", ramaddr, e.addr);
                if (!e.who) begin
                    chk("iload", iload, e.load);
                    chk("ramREN_i", 32'(ramREN), 32'd1);
                    chk("dload_idle", dload, 32'h0);
                end else begin
                    chk("dload", dload, e.load);
                    chk("ramWEN", 32'(ramWEN), 32'(e.wr));
                    chk("ramREN_d", 32'(ramREN), 32'(!e.wr));
                    if (e.wr) chk("ramstore", ramstore, e.store);
                    chk("iload_idle", iload, 32'h0);
                end
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic d_wait(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (dwait && n < 200);
        if (dwait) chk("d_timeout", 32'(dwait), 32'd0);
        tick();
    endtask

    task automatic i_wait(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (iwait && n < 200);
        if (iwait) chk("i_timeout", 32'(iwait), 32'd0);
        tick();
    endtask

    task automatic i_access(input word_t a);
        int n;
        iREN  = 1'b1;
        iaddr = a;
        i_wait(n);
        iREN  = 1'b0;
    endtask

    task automatic d_access(input logic wr, input word_t a, input word_t st);
        int n;
        dREN   = !wr;
        dWEN   = wr;
        daddr  = a;
        dstore = st;
        d_wait(n);
        dREN   = 1'b0;
        dWEN   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; lat = 4'd2; err_cfg = 0;
        repeat (2) @(negedge CLK);
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_iload", iload, 32'h0);
        chk("rst_dload", dload, 32'h0);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_state", 32'(dut.u_fsm.state), 32'(IDLE));
        tick();
        nRST = 1'b1;
        tick();

        // icache alone, latency 2
        expect_i(32'h40, 32'hDEAD_BEEF);
        iREN = 1'b1; iaddr = 32'h40;
        @(negedge CLK); chk("t1_ren_c0", 32'(ramREN), 32'd0);
        @(negedge CLK); chk("t1_ren_c1", 32'(ramREN), 32'd1);
        chk("t1_addr_c1", ramaddr, 32'h40);
        @(negedge CLK); chk("t1_busy_c2", 32'(iwait), 32'd1);
        @(negedge CLK); chk("t1_done_c3", 32'(iwait), 32'd0);
        @(negedge CLK); chk("t1_ren_after", 32'(ramREN), 32'd0);
        chk("t1_iwait_after", 32'(iwait), 32'd1);
        iREN = 1'b0;
        tick();

        // simultaneous requests: dcache first
        expect_d(1'b0, 32'h80, 32'hCAFE_0080, 32'h0);
        expect_i(32'h0, 32'h0000_1111);
        fork
            i_access(32'h0);
            d_access(1'b0, 32'h80, 32'h0);
        join
        repeat (2) tick();

        // block lock held across a one-cycle dcache gap
        lat = 4'd1;
        expect_d(1'b1, 32'h100, 32'h0, 32'h1111_0100);
        expect_d(1'b1, 32'h104, 32'h0, 32'h1111_0104);
        expect_i(32'h200, 32'hA5A5_0200);
        fork
            i_access(32'h200);
            begin
                dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1111_0100;
                d_wait(nd);
                dWEN = 1'b0;
                tick();
                dWEN = 1'b1; daddr = 32'h104; dstore = 32'h1111_0104;
                d_wait(nd);
                dWEN = 1'b0;
            end
        join
        repeat (2) tick();

        // three-cycle gap: lock releases and the icache slips in
        expect_d(1'b1, 32'h100, 32'h0, 32'h2222_0100);
        expect_i(32'h204, 32'hA5A5_0204);
        expect_d(1'b1, 32'h104, 32'h0, 32'h2222_0104);
        fork
            i_access(32'h204);
            begin
                dWEN = 1'b1; daddr = 32'h100; dstore = 32'h2222_0100;
                d_wait(nd);
                dWEN = 1'b0;
                repeat (3) tick();
                dWEN = 1'b1; daddr = 32'h104; dstore = 32'h2222_0104;
                d_wait(nd);
                dWEN = 1'b0;
            end
        join
        repeat (2) tick();

        // starvation: four dcache wins, then the icache is forced through
        lat = 4'd0;
        expect_d(1'b0, 32'h104, 32'hA5A5_0104, 32'h0);
        expect_d(1'b0, 32'h10C, 32'hA5A5_010C, 32'h0);
        expect_d(1'b0, 32'h114, 32'hA5A5_0114, 32'h0);
        expect_d(1'b0, 32'h11C, 32'hA5A5_011C, 32'h0);
        expect_i(32'h300, 32'hA5A5_0300);
        expect_d(1'b0, 32'h124, 32'hA5A5_0124, 32'h0);
        fork
            begin
                i_access(32'h300);
                chk("t4_starve_cleared", 32'(dut.u_fsm.starve_cnt), 32'd0);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    dREN  = 1'b1;
                    daddr = 32'h104 + 32'(8 * k);
                    d_wait(nd);
                end
                dREN = 1'b0;
            end
        join
        repeat (2) tick();

        // ERROR holds the access until ACCESS arrives
        err_cfg = 5;
        expect_d(1'b0, 32'h8C, 32'hA5A5_008C, 32'h0);
        dREN = 1'b1; daddr = 32'h8C;
        d_wait(nd);
        dREN = 1'b0;
        chk("t5_err_latency", 32'(nd), 32'd7);
        err_cfg = 0;
        repeat (2) tick();

        // request dropped mid-BUSY: back to IDLE, no completion
        lat = 4'd3;
        dREN = 1'b1; daddr = 32'h9C;
        @(negedge CLK);
        @(negedge CLK); chk("t6_ren", 32'(ramREN), 32'd1);
        tick();
        dREN = 1'b0;
        @(negedge CLK); chk("t6_dwait_drop", 32'(dwait), 32'd1);
        @(negedge CLK); chk("t6_state_idle", 32'(dut.u_fsm.state), 32'(IDLE));
        repeat (3) tick();

        // asynchronous reset in the middle of a dcache write
        lat = 4'd5;
        dWEN = 1'b1; daddr = 32'h1A4; dstore = 32'h5555_01A4;
        @(negedge CLK);
        @(negedge CLK); chk("t7_wen_before", 32'(ramWEN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("t7_ramWEN", 32'(ramWEN), 32'd0);
        chk("t7_ramREN", 32'(ramREN), 32'd0);
        chk("t7_dwait", 32'(dwait), 32'd1);
        chk("t7_iwait", 32'(iwait), 32'd1);
        chk("t7_ramaddr", ramaddr, 32'h0);
        dWEN = 1'b0;
        tick();
        nRST = 1'b1;
        repeat (3) tick();

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
